jtkicker_rom_slot: RTL and testbench

- SDRAM-side responder for a graphics layer's ROM fetch port (rom_addr / rom_data / rom_ok).
- Turns each 32-bit word request from the tile or sprite fetcher into one two-beat 16-bit SDRAM read.
- Keeps the last fetched word in a single-entry cache, so repeated reads of the same address return immediately.
- Sits between a layer (for example the scroll tilemap) and the SDRAM arbiter, one instance per layer ROM.

---
 rtl/jtkicker_rom_slot.sv | 111 +++++++++++
 tb/tb_jtkicker_rom_slot.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkicker_rom_slot.sv
// SDRAM-side responder for one layer ROM port: one 32-bit client word becomes
// a two-beat 16-bit SDRAM read, with the last fetched word kept in a one-entry cache.
module jtkicker_rom_slot #(
  parameter int          AW     = 12,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          rom_cs,
  input  logic [AW-1:0] rom_addr,
  output logic [31:0]   rom_data,
  output logic          rom_ok,
  output logic [21:0]   sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          sdram_dst,
  input  logic [15:0]   sdram_din
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    D0   = 2'd2,
    D1   = 2'd3
  } state_t;

  state_t          state;
  logic            valid;
  logic            discard;
  logic [AW-1:0]   tag;
  logic [AW-1:0]   req_addr;
  logic [15:0]     low;
  logic            hit;

  // Client word a lives at SDRAM words OFFSET+2a and OFFSET+2a+1; the sum wraps at 22 bits.
  function automatic logic [21:0] word_addr(input logic [AW-1:0] a);
    logic [AW:0] dbl;
    dbl = {a, 1'b0};
    return OFFSET + 22'(dbl);
  endfunction

  assign hit    = valid && (tag == rom_addr);
  assign rom_ok = rom_cs && hit;

  // Fetch sequencer: IDLE -> REQ (wait ack) -> D0 (low beat) -> D1 (high beat, fill cache).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= 1'b0;
      discard    <= 1'b0;
      tag        <= '0;
      req_addr   <= '0;
      low        <= 16'h0000;
      rom_data   <= 32'h0000_0000;
      sdram_req  <= 1'b0;
      sdram_addr <= OFFSET;
    end else begin
      if (clr) begin
        valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (rom_cs && !hit && !clr) begin
            req_addr   <= rom_addr;
            sdram_addr <= word_addr(rom_addr);
            sdram_req  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (clr) begin
            discard <= 1'b1;
          end
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= D0;
          end
        end
        D0: begin
          if (clr) begin
            discard <= 1'b1;
          end
          if (sdram_dst) begin
            low   <= sdram_din;
            state <= D1;
          end
        end
        D1: begin
          if (sdram_dst) begin
            // A clr seen anywhere during the fetch (or on this edge) keeps the entry invalid.
            rom_data <= {sdram_din, low};
            tag      <= req_addr;
            valid    <= !discard && !clr;
            discard  <= 1'b0;
            state    <= IDLE;
          end else if (clr) begin
            discard <= 1'b1;
          end
        end
        default: begin
          sdram_req <= 1'b0;
          discard   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtkicker_rom_slot.sv
// Bench for jtkicker_rom_slot: directed cases plus randomized traffic checked
// against a transaction-level cache model and an SDRAM image.
module tb_jtkicker_rom_slot;

  localparam logic [21:0] OFF_A = 22'h10000;
  localparam logic [21:0] OFF_W = 22'h3FFFFE;

  logic        clk = 1'b0;
  logic        rst_n, clr, rom_cs;
  logic [11:0] rom_addr;
  logic [31:0] rom_data, w_rom_data;
  logic        rom_ok, w_rom_ok;
  logic [21:0] sdram_addr, w_sdram_addr;
  logic        sdram_req, w_sdram_req;
  logic        sdram_ack, sdram_dst;
  logic [15:0] sdram_din;

  int n_tests = 0;
  int n_fail  = 0;

  // transaction-level model of the cache entry
  bit          m_valid;
  logic [11:0] m_tag;
  logic [15:0] mem [logic [21:0]];

  always #5 clk = ~clk;

  jtkicker_rom_slot #(.AW(12), .OFFSET(OFF_A)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok), .sdram_addr(sdram_addr), .sdram_req(sdram_req),
    .sdram_ack(sdram_ack), .sdram_dst(sdram_dst), .sdram_din(sdram_din)
  );

  jtkicker_rom_slot #(.AW(12), .OFFSET(OFF_W)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(w_rom_data), .rom_ok(w_rom_ok), .sdram_addr(w_sdram_addr), .sdram_req(w_sdram_req),
    .sdram_ack(sdram_ack), .sdram_dst(sdram_dst), .sdram_din(sdram_din)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] exp_addr(input logic [21:0] off, input logic [11:0] a);
    return off + {9'd0, a, 1'b0};
  endfunction

  function automatic logic [15:0] rd(input logic [21:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'(a[15:0] * 16'd40503) ^ {10'd0, a[21:16]} ^ 16'h5A5A;
  endfunction

  function automatic logic [31:0] exp_word(input logic [11:0] a);
    logic [21:0] ea;
    ea = exp_addr(OFF_A, a);
    return {rd(ea + 22'd1), rd(ea)};
  endfunction

  task automatic wait_req(input logic [11:0] a);
    int n;
    n = 0;
    while (sdram_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_seen", 32'(sdram_req), 32'd1);
    check_eq("req_addr", 32'(sdram_addr), 32'(exp_addr(OFF_A, a)));
    check_eq("wrap_addr", 32'(w_sdram_addr), 32'(exp_addr(OFF_W, a)));
    check_eq("wrap_req", 32'(w_sdram_req), 32'(sdram_req));
  endtask

  // Arbiter grant after w cycles; a stray strobe during REQ must be ignored.
  task automatic do_ack(input int w);
    for (int i = 0; i < w; i++) begin
      if (i == 0) begin
        sdram_dst = 1'b1;
        sdram_din = 16'hFFFF;
      end
      @(negedge clk);
      sdram_dst = 1'b0;
    end
    check_eq("req_hold", 32'(sdram_req), 32'd1);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    check_eq("req_drop", 32'(sdram_req), 32'd0);
  endtask

  task automatic beat(input logic [15:0] d, input int gap);
    repeat (gap) @(negedge clk);
    sdram_din = d;
    sdram_dst = 1'b1;
    @(negedge clk);
    sdram_dst = 1'b0;
  endtask

  task automatic serve(input logic [11:0] a, input int w, input bit clr_last);
    logic [21:0] ea;
    ea = exp_addr(OFF_A, a);
    wait_req(a);
    do_ack(w);
    beat(rd(ea), int'($urandom_range(0, 2)));
    if (clr_last) begin
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      beat(rd(ea + 22'd1), 0);
    end else begin
      beat(rd(ea + 22'd1), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pool [6];
    int reqs;
    pool = '{12'h000, 12'h001, 12'hFFF, 12'h7FF, 12'h123, 12'h800};
    rst_n = 1'b0; clr = 1'b0; rom_cs = 1'b1; rom_addr = 12'h000;
    sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_din = 16'h0000;
    m_valid = 1'b0; m_tag = 12'h000;
    mem[22'h10246] = 16'hBEEF;
    mem[22'h10247] = 16'hDEAD;

    repeat (2) @(negedge clk);
    check_eq("rst_ok", 32'(rom_ok), 32'd0);
    check_eq("rst_req", 32'(sdram_req), 32'd0);
    check_eq("rst_addr", 32'(sdram_addr), 32'(OFF_A));
    check_eq("rst_waddr", 32'(w_sdram_addr), 32'(OFF_W));
    check_eq("rst_data", rom_data, 32'h0);
    rom_cs = 1'b0;
    rst_n  = 1'b1;

    // cold miss
    @(negedge clk);
    rom_cs = 1'b1; rom_addr = 12'h123;
    #1 check_eq("cold_ok0", 32'(rom_ok), 32'd0);
    @(negedge clk);
    check_eq("cold_req_lat", 32'(sdram_req), 32'd1);
    check_eq("cold_addr", 32'(sdram_addr), 32'h10246);
    wait_req(12'h123);
    do_ack(0);
    beat(16'hBEEF, 0);
    check_eq("cold_ok_mid", 32'(rom_ok), 32'd0);
    beat(16'hDEAD, 0);
    check_eq("cold_ok", 32'(rom_ok), 32'd1);
    check_eq("cold_data", rom_data, 32'hDEADBEEF);
    m_valid = 1'b1; m_tag = 12'h123;

    // hit: no traffic for 20 cycles
    reqs = 0;
    repeat (20) begin
      @(negedge clk);
      reqs += int'(sdram_req);
      check_eq("hit_ok", 32'(rom_ok), 32'd1);
    end
    check_eq("hit_noreq", 32'(reqs), 32'd0);

    // address change mid-fetch
    rom_addr = 12'h010;
    @(negedge clk);
    wait_req(12'h010);
    do_ack(0);
    rom_addr = 12'h011;
    beat(rd(exp_addr(OFF_A, 12'h010)), 1);
    beat(rd(exp_addr(OFF_A, 12'h010) + 22'd1), 0);
    m_valid = 1'b1; m_tag = 12'h010;
    check_eq("chg_ok0", 32'(rom_ok), 32'd0);
    check_eq("chg_data", rom_data, exp_word(12'h010));
    serve(12'h011, 0, 1'b0);
    m_tag = 12'h011;
    check_eq("chg_ok1", 32'(rom_ok), 32'd1);
    check_eq("chg_data1", rom_data, exp_word(12'h011));

    // clr during D1
    rom_addr = 12'h055;
    serve(12'h055, 2, 1'b1);
    m_valid = 1'b0;
    #1 check_eq("clrd1_ok", 32'(rom_ok), 32'd0);
    @(negedge clk);
    check_eq("clrd1_rereq", 32'(sdram_req), 32'd1);
    serve(12'h055, 0, 1'b0);
    m_valid = 1'b1; m_tag = 12'h055;
    check_eq("clrd1_ok1", 32'(rom_ok), 32'd1);

    // wrap-around on the second instance
    rom_addr = 12'h002;
    @(negedge clk);
    check_eq("wrap_const", 32'(w_sdram_addr), 32'h000002);
    serve(12'h002, 1, 1'b0);
    m_tag = 12'h002;
    check_eq("wrap_data", w_rom_data, exp_word(12'h002));

    // async reset in D0
    rom_addr = 12'h077;
    wait_req(12'h077);
    do_ack(0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_ok", 32'(rom_ok), 32'd0);
    check_eq("arst_req", 32'(sdram_req), 32'd0);
    m_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; rom_cs = 1'b0;
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    beat(16'h1234, 0);
    beat(16'h5678, 1);
    check_eq("arst_data", rom_data, 32'h0);
    check_eq("arst_noreq", 32'(sdram_req), 32'd0);
    rom_cs = 1'b1;
    #1 check_eq("arst_valid", 32'(rom_ok), 32'd0);
    serve(12'h077, 0, 1'b0);
    m_valid = 1'b1; m_tag = 12'h077;
    check_eq("arst_refill", rom_data, exp_word(12'h077));

    // randomized traffic against the model
    for (int it = 0; it < 80; it++) begin
      logic [11:0] a;
      bit cs, ehit, cl;
      int r;
      a  = pool[$urandom_range(0, 5)];
      cs = ($urandom_range(0, 9) != 0);
      r  = int'($urandom_range(0, 9));
      rom_cs = cs; rom_addr = a;
      #1;
      ehit = m_valid && (m_tag == a);
      check_eq("rnd_ok", 32'(rom_ok), 32'(cs && ehit));
      if (cs && ehit) check_eq("rnd_data", rom_data, exp_word(a));
      if (r == 0 && cs) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_valid = 1'b0;
        check_eq("rnd_clr_noreq", 32'(sdram_req), 32'd0);
      end else if (cs && !ehit) begin
        cl = (r < 3);
        serve(a, int'($urandom_range(0, 3)), cl);
        m_valid = !cl; m_tag = a;
        if (!cl) begin
          #1;
          check_eq("rnd_fill_ok", 32'(rom_ok), 32'd1);
          check_eq("rnd_fill_data", rom_data, exp_word(a));
        end
      end else begin
        @(negedge clk);
        check_eq("rnd_noreq", 32'(sdram_req), 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
